// File: rtl/mux1_2x1_reg.sv
// WIDTH-bit 2:1 selector with a zero-latency output, an enabled registered copy,
// and a saturating counter of select transitions for debug visibility.
module mux1_2x1_reg #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             S,
  input  logic             en,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_R,
  output logic             S_R,
  output logic [CNT_W-1:0] sel_toggles
);

  logic [WIDTH-1:0] yR_q, yR_d;
  logic             sR_q, sR_d;
  logic             prevS_q, prevS_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             selChanged;

  assign Y = S ? I1 : I0;

  // Previous-S tracks every edge so toggles are counted even while en is low.
  always_comb begin
    yR_d       = yR_q;
    sR_d       = sR_q;
    prevS_d    = S;
    cnt_d      = cnt_q;
    selChanged = (S != prevS_q);
    if (en) begin
      yR_d = Y;
      sR_d = S;
    end
    if (selChanged && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yR_q    <= '0;
      sR_q    <= 1'b0;
      prevS_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      yR_q    <= yR_d;
      sR_q    <= sR_d;
      prevS_q <= prevS_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Y_R         = yR_q;
  assign S_R         = sR_q;
  assign sel_toggles = cnt_q;

endmodule

// File: tb/tb_mux1_2x1_reg.sv
// Scoreboard bench: instance A (WIDTH=8, CNT_W=8) and instance B (WIDTH=1, CNT_W=2)
// share clock and reset; directed steps push expectations, a monitor pops and compares.
module tb_mux1_2x1_reg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [7:0] i0A = '0, i1A = '0;
  logic       sA = 1'b0, enA = 1'b0;
  logic [7:0] yA, yRA, cntA;
  logic       sRA;

  logic       i0B = 1'b0, i1B = 1'b0;
  logic       sB = 1'b0, enB = 1'b0;
  logic       yB, yRB, sRB;
  logic [1:0] cntB;

  typedef struct {
    int          id;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t sbq[$];
  int    total = 0;
  int    bad = 0;
  event  monTick;

  mux1_2x1_reg #(.WIDTH(8), .CNT_W(8)) dutA (
    .clk(clk), .rst_n(rst_n), .I0(i0A), .I1(i1A), .S(sA), .en(enA),
    .Y(yA), .Y_R(yRA), .S_R(sRA), .sel_toggles(cntA)
  );

  mux1_2x1_reg #(.WIDTH(1), .CNT_W(2)) dutB (
    .clk(clk), .rst_n(rst_n), .I0(i0B), .I1(i1B), .S(sB), .en(enB),
    .Y(yB), .Y_R(yRB), .S_R(sRB), .sel_toggles(cntB)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] getActual(input int id);
    case (id)
      0:       return {24'b0, yA};
      1:       return {24'b0, yRA};
      2:       return {31'b0, sRA};
      3:       return {24'b0, cntA};
      4:       return {31'b0, yB};
      5:       return {31'b0, yRB};
      6:       return {31'b0, sRB};
      default: return {30'b0, cntB};
    endcase
  endfunction

  task automatic pushExp(input int id, input logic [31:0] exp, input string name);
    item_t it;
    it.id = id;
    it.exp = exp;
    it.name = name;
    sbq.push_back(it);
  endtask

  // Inputs change just after a rising edge; expectations are checked at the next falling edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input logic [7:0] y, input logic [7:0] yR, input logic sR,
                             input logic [7:0] cnt, input string tag);
    pushExp(0, {24'b0, y}, {tag, ".Y"});
    pushExp(1, {24'b0, yR}, {tag, ".Y_R"});
    pushExp(2, {31'b0, sR}, {tag, ".S_R"});
    pushExp(3, {24'b0, cnt}, {tag, ".cnt"});
  endtask

  initial begin : monitor
    item_t it;
    logic [31:0] act;
    forever begin
      @(negedge clk or monTick);
      while (sbq.size() > 0) begin
        it = sbq.pop_front();
        act = getActual(it.id);
        total++;
        if (act !== it.exp) begin
          bad++;
          $display("[TB] FAIL %s: got %0h expected %0h at %0t", it.name, act, it.exp, $time);
        end
      end
    end
  end

  initial begin : stimulus
    logic [2:0] tt [8];
    logic       ttY [8];
    int         waitCnt;
    tt = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111};
    ttY = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    applyStimulus();
    checkOutput(8'h00, 8'h00, 1'b0, 8'h00, "rstA");
    pushExp(5, 0, "rstB.Y_R");
    pushExp(6, 0, "rstB.S_R");
    pushExp(7, 0, "rstB.cnt");
    rst_n = 1'b1;

    // Truth table on the 1-bit instance, order (I0,I1,S).
    for (int i = 0; i < 8; i++) begin
      applyStimulus();
      i0B = tt[i][2];
      i1B = tt[i][1];
      sB  = tt[i][0];
      pushExp(4, {31'b0, ttY[i]}, $sformatf("tt%0d.Y", i));
    end

    applyStimulus();
    i0A = 8'hA5; i1A = 8'h3C; sA = 1'b0; enA = 1'b1;
    checkOutput(8'hA5, 8'h00, 1'b0, 8'h00, "A1");
    applyStimulus();
    sA = 1'b1;
    checkOutput(8'h3C, 8'hA5, 1'b0, 8'h00, "A2");
    applyStimulus();
    checkOutput(8'h3C, 8'h3C, 1'b1, 8'h01, "A3");

    // Enable low: Y_R/S_R freeze while Y and the toggle counter keep moving.
    applyStimulus();
    enA = 1'b0; sA = 1'b0; i0A = 8'h11; i1A = 8'h22;
    checkOutput(8'h11, 8'h3C, 1'b1, 8'h01, "A4");
    applyStimulus();
    sA = 1'b1; i0A = 8'h33; i1A = 8'h44;
    checkOutput(8'h44, 8'h3C, 1'b1, 8'h02, "A5");
    applyStimulus();
    sA = 1'b0; i0A = 8'h55;
    checkOutput(8'h55, 8'h3C, 1'b1, 8'h03, "A6");
    applyStimulus();
    sA = 1'b1; enA = 1'b1; i0A = 8'h00; i1A = 8'h01;
    checkOutput(8'h01, 8'h3C, 1'b1, 8'h04, "A7");
    applyStimulus();
    sA = 1'b0;
    checkOutput(8'h00, 8'h01, 1'b1, 8'h05, "A8");

    // Mid-cycle asynchronous reset with Y_R=1 and count=5, checked before any rising edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput(8'h00, 8'h00, 1'b0, 8'h00, "rstMid");
    ->monTick;

    applyStimulus();
    checkOutput(8'h00, 8'h00, 1'b0, 8'h00, "rstHold");
    sB = 1'b0; enB = 1'b0;
    rst_n = 1'b1;

    // Saturation on the 2-bit counter.
    applyStimulus();
    sB = 1'b1;
    pushExp(7, 0, "sat0");
    for (int k = 1; k <= 6; k++) begin
      applyStimulus();
      sB = (k < 5) ? ~sB : 1'b0;
      if (k == 5) sB = 1'b0;
      pushExp(7, (k < 3) ? k : 3, $sformatf("sat%0d", k));
    end

    waitCnt = 0;
    while (sbq.size() > 0 && waitCnt < 10) begin
      @(posedge clk);
      waitCnt++;
    end
    if (sbq.size() > 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
